// File: rtl/programmable_sq_wave_gen_pkg.sv
// Shared definitions for the programmable square-wave generator.
//   phase_t           : ON (output high) / OFF (output low) phase encoding
//   CLK_PER_TICK_DEF  : default system clocks per 100 ns time-base tick
//   CTRL_W_DEF        : default width of the ON/OFF duration controls
package programmable_sq_wave_gen_pkg;

   localparam int CLK_PER_TICK_DEF = 10;
   localparam int CTRL_W_DEF       = 4;

   typedef enum logic {
      ON  = 1'b0,
      OFF = 1'b1
   } phase_t;

endpackage

// File: rtl/programmable_sq_wave_gen_tick_counter.sv
// Free-running modulo-M prescaler. Counts 0..M-1 and wraps to 0; max_tick is
// high for the single clock in which the count sits at M-1.
//   clk      : system clock
//   reset    : asynchronous active-low reset (count returns to 0)
//   max_tick : one-clock pulse at the last count of every M-clock window
module mod_m_tick_counter #(
   parameter int M = 10
) (
   input  logic clk,
   input  logic reset,
   output logic max_tick
);

   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign max_tick = (cnt_q == LAST);

endmodule

// File: rtl/programmable_sq_wave_gen.sv
// Programmable square-wave generator on a 100 ns time base.
//   clk            : 100 MHz system clock
//   reset          : asynchronous active-low reset
//   ctrl_on        : ON duration in ticks (0 behaves as 1)
//   ctrl_off       : OFF duration in ticks (0 behaves as 1)
//   sq_wave        : registered square-wave output
//   debug_ns_tick  : one-clock pulse at the end of every tick
//   debug_ns_count : registered toggle flipping on every tick
//
// state | meaning
// ------+-------------------------------------------
// ON    | sq_wave high, counting ctrl_on ticks
// OFF   | sq_wave low, counting ctrl_off ticks
module programmable_sq_wave_gen
   import programmable_sq_wave_gen_pkg::*;
#(
   parameter int CLK_PER_TICK = CLK_PER_TICK_DEF,
   parameter int CTRL_W       = CTRL_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CTRL_W-1:0] ctrl_on,
   input  logic [CTRL_W-1:0] ctrl_off,
   output logic              sq_wave,
   output logic              debug_ns_tick,
   output logic              debug_ns_count
);

   logic              tick;
   phase_t            state_q;
   logic [CTRL_W-1:0] phase_cnt_q;
   logic              sq_wave_q;
   logic              ns_count_q;
   logic [CTRL_W-1:0] ctrl_sel;
   logic [CTRL_W-1:0] eff_len;
   logic              phase_done;

   mod_m_tick_counter #(
      .M (CLK_PER_TICK)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .max_tick (tick)
   );

   assign ctrl_sel = (state_q == ON) ? ctrl_on : ctrl_off;
   assign eff_len  = (ctrl_sel == '0) ? CTRL_W'(1) : ctrl_sel;

   // Greater-or-equal so a control lowered mid-phase ends the phase on the
   // next tick instead of letting the counter run on and wrap.
   assign phase_done = ({1'b0, phase_cnt_q} + (CTRL_W + 1)'(1)) >= {1'b0, eff_len};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ON;
         phase_cnt_q <= '0;
         sq_wave_q   <= 1'b1;
         ns_count_q  <= 1'b0;
      end else if (tick) begin
         ns_count_q <= ~ns_count_q;
         if (phase_done) begin
            phase_cnt_q <= '0;
            if (state_q == ON) begin
               state_q   <= OFF;
               sq_wave_q <= 1'b0;
            end else begin
               state_q   <= ON;
               sq_wave_q <= 1'b1;
            end
         end else begin
            phase_cnt_q <= phase_cnt_q + CTRL_W'(1);
         end
      end
   end

   assign sq_wave        = sq_wave_q;
   assign debug_ns_tick  = tick;
   assign debug_ns_count = ns_count_q;

endmodule

// File: tb/tb_programmable_sq_wave_gen.sv
// Bench for programmable_sq_wave_gen. Expected outputs come from closed-form
// arithmetic on the number of clock edges since reset release.
module tb_programmable_sq_wave_gen;

   localparam int CPT = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] ctrl_on = 4'd1;
   logic [3:0] ctrl_off = 4'd3;
   logic       sq_wave;
   logic       debug_ns_tick;
   logic       debug_ns_count;

   int checks = 0;
   int failures = 0;

   programmable_sq_wave_gen #(
      .CLK_PER_TICK (CPT),
      .CTRL_W       (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ctrl_on        (ctrl_on),
      .ctrl_off       (ctrl_off),
      .sq_wave        (sq_wave),
      .debug_ns_tick  (debug_ns_tick),
      .debug_ns_count (debug_ns_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp_v, $time);
      end
   endtask

   // Reference: t = rising edges since reset release, sampled at a falling edge.
   function automatic logic ref_sq(input int t, input int on_v, input int off_v);
      int eon, eoff, per;
      eon  = (on_v == 0) ? 1 : on_v;
      eoff = (off_v == 0) ? 1 : off_v;
      per  = (eon + eoff) * CPT;
      return ((t % per) < (eon * CPT));
   endfunction

   // Apply controls under reset, release on a falling edge.
   task automatic restart(input int on_v, input int off_v);
      @(negedge clk);
      reset = 1'b0;
      ctrl_on = 4'(on_v);
      ctrl_off = 4'(off_v);
      @(negedge clk);
      chk("rst_sq", 32'(sq_wave), 32'd1);
      chk("rst_tick", 32'(debug_ns_tick), 32'd0);
      chk("rst_cnt", 32'(debug_ns_count), 32'd0);
      reset = 1'b1;
   endtask

   // Run n cycles from t0 checking all outputs; also measures run lengths.
   task automatic run_check(input int n, input int on_v, input int off_v, input string tag);
      int hi_len, lo_len, ticks_on, eon, eoff;
      logic prev;
      eon  = (on_v == 0) ? 1 : on_v;
      eoff = (off_v == 0) ? 1 : off_v;
      hi_len = 0; lo_len = 0; ticks_on = 0; prev = 1'b1;
      for (int t = 0; t < n; t++) begin
         chk({tag, "_sq"}, 32'(sq_wave), 32'(ref_sq(t, on_v, off_v)));
         chk({tag, "_tick"}, 32'(debug_ns_tick), 32'((t % CPT) == CPT - 1));
         chk({tag, "_cnt"}, 32'(debug_ns_count), 32'((t / CPT) % 2));
         if (sq_wave && debug_ns_tick) ticks_on++;
         if (sq_wave) hi_len++; else lo_len++;
         if (prev && !sq_wave && t > 0) begin
            // first ON phase has just ended: its length and tick count
            chk({tag, "_hi_len"}, 32'(hi_len), 32'(eon * CPT));
            chk({tag, "_on_ticks"}, 32'(ticks_on), 32'(eon));
         end
         if (!prev && sq_wave && lo_len > 0) begin
            chk({tag, "_lo_len"}, 32'(lo_len), 32'(eoff * CPT));
            lo_len = 0;
         end
         if (sq_wave && !prev) begin hi_len = 1; ticks_on = debug_ns_tick ? 1 : 0; end
         prev = sq_wave;
         @(negedge clk);
      end
   endtask

   initial begin
      int on_v, off_v;
      // Directed: 1/3 for 1 us plus margin
      restart(1, 3);
      run_check(110, 1, 3, "d13");
      // Directed: 15/15 over two periods
      restart(15, 15);
      run_check(620, 15, 15, "d1515");
      // Directed: 0/0 behaves as 1/1
      restart(0, 0);
      run_check(80, 0, 0, "d00");

      // Reset in the middle of an OFF phase (2/3: OFF spans t=20..49)
      restart(2, 3);
      run_check(30, 2, 3, "pre");
      #2 reset = 1'b0;
      #1;
      chk("async_sq", 32'(sq_wave), 32'd1);
      chk("async_cnt", 32'(debug_ns_count), 32'd0);
      chk("async_tick", 32'(debug_ns_tick), 32'd0);
      repeat (3) @(negedge clk);
      chk("held_sq", 32'(sq_wave), 32'd1);
      reset = 1'b1;
      run_check(120, 2, 3, "post");

      // Randomized control pairs
      for (int i = 0; i < 8; i++) begin
         on_v  = int'($urandom_range(0, 15));
         off_v = int'($urandom_range(0, 15));
         restart(on_v, off_v);
         run_check(2 * ((on_v == 0 ? 1 : on_v) + (off_v == 0 ? 1 : off_v)) * CPT + 15,
                   on_v, off_v, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/programmable_sq_wave_gen.md
# programmable_sq_wave_gen

Programmable square-wave generator driven by a fixed 100 ns time base derived from the 100 MHz system clock. The ON (high) time and OFF (low) time are each set in 100 ns units by two 4-bit control inputs. The block is a leaf peripheral: the sq_wave output drives a pin or LED. The debug outputs expose the internal time base to benches and logic analysers.

## Interface
- CLK_PER_TICK, 10: system clocks per time-base tick (10 × 10 ns = 100 ns); must be ≥ 2.
- CTRL_W, 4: width of ctrl_on / ctrl_off.
- clk  in  1  system clock, 100 MHz, rising-edge.
- reset  in  1  One clock; reset is asynchronous and active-low. Asserting reset = 0 clears all state immediately.
- ctrl_on  in  CTRL_W  ON duration in ticks; 0 is treated as 1.
- ctrl_off  in  CTRL_W  OFF duration in ticks; 0 is treated as 1.
- sq_wave  out  1  square-wave output, registered.
- debug_ns_tick  out  1  one-clock pulse at the end of every 100 ns tick.
- debug_ns_count  out  1  registered; toggles on every tick (square wave at half the tick rate).

## Operation
- Prescaler: counter 0..CLK_PER_TICK-1, increments every clock, wraps to 0. debug_ns_tick = (prescaler == CLK_PER_TICK-1).
- Phase FSM, two states:
  - ON: sq_wave = 1.
  - OFF: sq_wave = 0.
- Phase counter: counts ticks within the current phase.
  - On a tick with phase_cnt == eff_len-1: toggle the state and clear phase_cnt.
  - On any other tick: increment phase_cnt.
  - eff_len = max(ctrl, 1), using ctrl_on in ON and ctrl_off in OFF.
- Control inputs are compared live every tick. The bench holds them stable within a phase.
- If a control input is lowered below phase_cnt+1 mid-phase, the phase ends at the next tick. The comparison is ≥, not ==, so the counter never wraps past 15.
- Phase counter is CTRL_W bits wide. The maximum 15 ticks needs no extra width.
- Period = (eff_on + eff_off) × CLK_PER_TICK clocks. Duty = eff_on / (eff_on + eff_off).

## Timing
- Reset values: prescaler 0, phase_cnt 0, state ON, sq_wave 1, debug_ns_tick 0, debug_ns_count 0.
- After reset release, the first tick pulse occurs in clock cycle CLK_PER_TICK-1 (10th cycle). Ticks then repeat every CLK_PER_TICK cycles.
- sq_wave changes on the rising edge immediately after the terminating tick cycle.
  - sq_wave is high for exactly eff_on×CLK_PER_TICK clocks, then low for eff_off×CLK_PER_TICK clocks.
  - The first ON phase after reset has full length.
- During each ON phase exactly eff_on ticks occur. The last one coincides with the phase switch, so eff_on-1 ticks are interior. The OFF phase behaves the same way.
- debug_ns_count updates on the same edge that follows a tick cycle.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. Operation restarts from the ON phase with full length.

## Structure
- Shared package: typedef enum {ON, OFF} phase_t; default constants for CLK_PER_TICK and CTRL_W.
- Sub-module mod_m_tick_counter (parameter M): free-running prescaler with a max_tick output. It is instantiated once with M = CLK_PER_TICK.
- The top level holds the phase FSM, phase counter, output registers and the debug toggle.

## Test plan
- ctrl_on=1, ctrl_off=3, run 1 µs after reset -> sq_wave high 10 clk, low 30 clk, period 400 ns, 2.5 periods; debug_ns_tick every 100 ns.
- ctrl_on=1, ctrl_off=3, count ticks per phase -> 1 tick per ON phase (0 interior), 3 ticks per OFF phase (2 interior).
- ctrl_on=15, ctrl_off=15 -> high 150 clk, low 150 clk; phase_cnt never exceeds 14.
- ctrl_on=0, ctrl_off=0 -> behaves as 1/1: 100 ns high, 100 ns low.
- Assert reset for 3 clk in the middle of an OFF phase -> sq_wave=1, debug_ns_count=0 immediately; after release, a full 10×ctrl_on-clock high phase follows.
- debug_ns_count -> toggles every 100 ns, period 200 ns, starts at 0 after reset.
